alu_seq_ctrl: RTL and testbench
===============================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 The block SHALL have parameter: wordSize, 32, datapath word width.
REQ-002 The block SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-003 The block SHALL have port: clr  in  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have ports: req_valid in 1 request strobe; req_ready out 1 request accept; req_opcode in 5 ALU opcode; req_a in wordSize operand A; req_b in wordSize operand B.
REQ-005 The block SHALL have ports: alu_y out wordSize temp-register (Y) value; alu_a out wordSize operand A; alu_b out wordSize operand B; alu_opcode out 5 issued opcode; alu_start out 1 one-cycle issue pulse.
REQ-006 The block SHALL have ports: alu_c in 2*wordSize ALU result; alu_done in 1 result-valid strobe from ALU.
REQ-007 The block SHALL have ports: rsp_valid out 1 result valid; rsp_ready in 1 consumer accept; rsp_lo out wordSize Z low; rsp_hi out wordSize Z high; rsp_err out 1 illegal opcode or timeout; op_count out 16 completed-response counter.

Function
REQ-008 The FSM SHALL have states IDLE, LOAD_Y, EXEC, WAIT, RESP.
REQ-009 req_ready SHALL be 1 only in IDLE with clr low.
REQ-010 IDLE: on req_valid&req_ready, latch opcode/A/B; legal opcode (1..15) -> LOAD_Y; illegal (0, 16..31) -> RESP with rsp_err=1, rsp_lo=rsp_hi=0.
REQ-011 LOAD_Y: alu_y SHALL take latched A; one cycle; -> EXEC.
REQ-012 EXEC: alu_start=1 for exactly this cycle; alu_opcode/alu_a/alu_b SHALL hold latched values from LOAD_Y until the next accept; -> WAIT.
REQ-013 WAIT: alu_done sampled each edge; when high, rsp_lo<=alu_c[wordSize-1:0], rsp_hi<=alu_c[2*wordSize-1:wordSize], rsp_err<=0, -> RESP.
REQ-014 WAIT SHALL keep a 6-bit cycle counter cleared on entry; if counter=63 and alu_done low -> RESP with rsp_err=1, rsp_lo=rsp_hi=0; alu_done high at counter=63 SHALL win (normal capture).
REQ-015 alu_done outside WAIT SHALL be ignored.
REQ-016 Minimum latency: accept at edge N, alu_start high in cycle after edge N+1, alu_done high in first WAIT cycle -> rsp_valid high after edge N+3.
REQ-017 RESP: rsp_valid=1; rsp_lo/rsp_hi/rsp_err stable until rsp_valid&rsp_ready; on that edge -> IDLE and op_count increments.
REQ-018 op_count SHALL count error responses too and wrap 0xFFFF -> 0x0000.
REQ-019 req_valid while not in IDLE SHALL be ignored (no latch, no queue).
REQ-020 rsp_valid and req_ready SHALL never both be 1; back-to-back: new request accepted no earlier than the edge after the response handshake.

Reset
REQ-021 clr high SHALL force, asynchronously and from any state (including mid-WAIT), state=IDLE, alu_start=0, rsp_valid=0, rsp_err=0, op_count=0, counter=0, and all data outputs (alu_y, alu_a, alu_b, alu_opcode, rsp_lo, rsp_hi) =0.
REQ-022 After clr falls, req_ready SHALL be 1 in the first cycle; no pending ALU result from before reset SHALL be captured.

Verification
REQ-023 Add: opcode=5'b00001, A=5, B=7, ALU returns C=0x0000_0000_0000_000C with done in first WAIT cycle -> rsp_lo=0x0000000C, rsp_hi=0, rsp_err=0, rsp_valid after edge N+3, op_count=1.
REQ-024 Div with 10-cycle done delay: opcode=5'b00100, A=100, B=7, C={32'd2,32'd14} -> rsp_hi=2, rsp_lo=14, alu_start exactly one cycle, rsp_valid 9 cycles later than REQ-023 case.
REQ-025 Illegal opcode 5'b00000 and 5'b10000 -> RESP next state, rsp_err=1, rsp_lo=rsp_hi=0, alu_start never asserted.
REQ-026 Timeout: legal opcode, alu_done held low -> rsp_err=1 after 64 WAIT cycles; repeat with alu_done pulsed at counter=63 -> normal capture, rsp_err=0.
REQ-027 Backpressure and wrap: hold rsp_ready=0 for 20 cycles -> rsp outputs stable, req_valid ignored; preload op_count to 0xFFFF via 65535 transactions -> next handshake gives 0x0000.
REQ-028 Reset mid-operation: assert clr in WAIT while alu_done pulses -> all outputs 0, state IDLE, req_ready=1 first cycle after release, no response emitted.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - request/response sequencer that issues one operation at a time to an external ALU
//
// Accepts one request (opcode, A, B). It loads the Y register, pulses alu_start and waits for
// alu_done, giving up after 64 WAIT cycles. It then presents the 2*wordSize result as a response
// that is held until the consumer accepts it.
//
// Ports:
//   clk, clr                  clock; asynchronous active-high reset
//   req_valid/req_ready       request handshake; req_opcode, req_a, req_b request payload
//   alu_y, alu_a, alu_b       operand registers presented to the ALU
//   alu_opcode, alu_start     issued opcode and its one-cycle issue strobe
//   alu_c, alu_done           ALU result and its valid strobe
//   rsp_valid/rsp_ready       response handshake; rsp_lo, rsp_hi, rsp_err response payload
//   op_count                  number of completed responses, including error responses (wraps)
module alu_seq_ctrl #(
    parameter int wordSize = 32
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [4:0]              req_opcode,
    input  logic [wordSize-1:0]     req_a,
    input  logic [wordSize-1:0]     req_b,
    output logic [wordSize-1:0]     alu_y,
    output logic [wordSize-1:0]     alu_a,
    output logic [wordSize-1:0]     alu_b,
    output logic [4:0]              alu_opcode,
    output logic                    alu_start,
    input  logic [2*wordSize-1:0]   alu_c,
    input  logic                    alu_done,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [wordSize-1:0]     rsp_lo,
    output logic [wordSize-1:0]     rsp_hi,
    output logic                    rsp_err,
    output logic [15:0]             op_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_Y,
        EXEC,
        WAIT,
        RESP
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [5:0] wait_cnt;
    logic       accept;
    logic       rsp_fire;
    logic       legal;

    // Opcodes 1..15 are implemented by the ALU; 0 and anything with bit 4 set are rejected.
    assign legal = (req_opcode != 5'd0) && !req_opcode[4];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        alu_start = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        rsp_fire  = 1'b0;
        case (state)
            IDLE: begin
                // Gate with clr so that a request offered during reset is never seen as accepted.
                req_ready = !clr;
                if (req_valid && !clr) begin
                    accept    = 1'b1;
                    state_nxt = legal ? LOAD_Y : RESP;
                end
            end
            LOAD_Y: state_nxt = EXEC;
            EXEC: begin
                alu_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (alu_done || (wait_cnt == 6'd63)) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    rsp_fire  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            alu_y      <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            rsp_lo     <= '0;
            rsp_hi     <= '0;
            rsp_err    <= 1'b0;
            op_count   <= '0;
            wait_cnt   <= '0;
        end else begin
            if (accept) begin
                alu_opcode <= req_opcode;
                alu_a      <= req_a;
                alu_b      <= req_b;
                if (!legal) begin
                    rsp_lo  <= '0;
                    rsp_hi  <= '0;
                    rsp_err <= 1'b1;
                end
            end
            case (state)
                LOAD_Y: alu_y <= alu_a;
                EXEC:   wait_cnt <= '0;
                WAIT: begin
                    wait_cnt <= wait_cnt + 6'd1;
                    // A result arriving on the last allowed cycle still counts as a normal completion.
                    if (alu_done) begin
                        {rsp_hi, rsp_lo} <= alu_c;
                        rsp_err          <= 1'b0;
                    end else if (wait_cnt == 6'd63) begin
                        rsp_lo  <= '0;
                        rsp_hi  <= '0;
                        rsp_err <= 1'b1;
                    end
                end
                default: ;
            endcase
            if (rsp_fire) begin
                op_count <= op_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - randomized self-checking bench for alu_seq_ctrl
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_opcode = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [31:0] alu_y, alu_a, alu_b;
    logic [4:0]  alu_opcode;
    logic        alu_start;
    logic [63:0] alu_c = '0;
    logic        alu_done = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_lo, rsp_hi;
    logic        rsp_err;
    logic [15:0] op_count;

    int          total = 0;
    int          bad = 0;
    int          start_cnt = 0;
    int          both_hi = 0;
    int          resp_delay = -1;
    logic [63:0] resp_c = '0;
    logic [15:0] exp_count = '0;

    alu_seq_ctrl #(.wordSize(32)) dut (
        .clk(clk), .clr(clr),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_a(req_a), .req_b(req_b),
        .alu_y(alu_y), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_start(alu_start),
        .alu_c(alu_c), .alu_done(alu_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_lo(rsp_lo), .rsp_hi(rsp_hi),
        .rsp_err(rsp_err), .op_count(op_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (alu_start === 1'b1) start_cnt++;
        if (rsp_valid === 1'b1 && req_ready === 1'b1) both_hi++;
    end

    // ALU model: answers resp_delay WAIT cycles after the issue strobe (never if negative).
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (alu_start === 1'b1 && resp_delay >= 0) begin
                repeat (resp_delay + 1) @(posedge clk);
                #1;
                alu_done = 1'b1;
                alu_c    = resp_c;
                @(posedge clk);
                #1;
                alu_done = 1'b0;
                alu_c    = $urandom;
            end
        end
    end

    // One full transaction; expectations come from the opcode/delay rules, not from DUT state.
    task automatic do_txn(input string name, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] c, input int d, input int hold);
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_lo, exp_hi;
        int          lat;
        int          starts0;
        bit          legal;
        legal = (op >= 5'd1) && (op <= 5'd15);
        if (!legal) begin
            exp_lat = 0; exp_err = 1'b1; exp_lo = '0; exp_hi = '0;
        end else if (d >= 0 && d <= 63) begin
            exp_lat = 3 + d; exp_err = 1'b0; exp_lo = c[31:0]; exp_hi = c[63:32];
        end else begin
            exp_lat = 66; exp_err = 1'b1; exp_lo = '0; exp_hi = '0;
        end
        resp_delay = d;
        resp_c     = c;
        starts0    = start_cnt;

        total++;
        if (req_ready !== 1'b1) begin
            bad++; $display("FAIL %s ready_before: got %b want 1", name, req_ready);
        end
        req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b;
        lat = 0;
        while (lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                req_valid = 1'b0; req_opcode = 5'($urandom); req_a = $urandom; req_b = $urandom;
            end
            if (rsp_valid === 1'b1) break;
        end
        total++;
        if (lat - 1 != exp_lat) begin
            bad++; $display("FAIL %s latency: got %0d want %0d", name, lat - 1, exp_lat);
        end
        total++;
        if (rsp_err !== exp_err || rsp_lo !== exp_lo || rsp_hi !== exp_hi) begin
            bad++; $display("FAIL %s result: got err=%b hi=%h lo=%h want err=%b hi=%h lo=%h",
                            name, rsp_err, rsp_hi, rsp_lo, exp_err, exp_hi, exp_lo);
        end
        total++;
        if (alu_opcode !== op || alu_a !== a || alu_b !== b) begin
            bad++; $display("FAIL %s operands: got op=%h a=%h b=%h want op=%h a=%h b=%h",
                            name, alu_opcode, alu_a, alu_b, op, a, b);
        end
        if (legal) begin
            total++;
            if (alu_y !== a) begin
                bad++; $display("FAIL %s alu_y: got %h want %h", name, alu_y, a);
            end
        end
        total++;
        if (start_cnt - starts0 != (legal ? 1 : 0)) begin
            bad++; $display("FAIL %s start_pulses: got %0d want %0d", name, start_cnt - starts0, legal ? 1 : 0);
        end
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1; req_opcode = 5'($urandom); req_a = $urandom; req_b = $urandom;
            @(posedge clk);
            #1;
            total++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_err !== exp_err ||
                rsp_lo !== exp_lo || rsp_hi !== exp_hi) begin
                bad++; $display("FAIL %s hold%0d: got v=%b rdy=%b err=%b hi=%h lo=%h want v=1 rdy=0 err=%b hi=%h lo=%h",
                                name, i, rsp_valid, req_ready, rsp_err, rsp_hi, rsp_lo, exp_err, exp_hi, exp_lo);
            end
        end
        req_valid = 1'b0;
        if (hold > 0) begin
            total++;
            if (alu_a !== a || alu_opcode !== op) begin
                bad++; $display("FAIL %s ignored_req: got op=%h a=%h want op=%h a=%h", name, alu_opcode, alu_a, op, a);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        exp_count = exp_count + 16'd1;
        total++;
        if (op_count !== exp_count || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++; $display("FAIL %s after_handshake: got cnt=%h v=%b rdy=%b want cnt=%h v=0 rdy=1",
                            name, op_count, rsp_valid, req_ready, exp_count);
        end
    endtask

    task automatic test_reset();
        total++;
        if ({alu_y, alu_a, alu_b, alu_opcode, rsp_lo, rsp_hi, op_count} !== '0 ||
            alu_start !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
            bad++; $display("FAIL reset_outputs: got y=%h a=%h b=%h op=%h lo=%h hi=%h cnt=%h want all 0",
                            alu_y, alu_a, alu_b, alu_opcode, rsp_lo, rsp_hi, op_count);
        end
        total++;
        if (req_ready !== 1'b0) begin
            bad++; $display("FAIL reset_ready_in_clr: got %b want 0", req_ready);
        end
        clr = 1'b0;
        #1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready_after: got %b want 1", req_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_add();
        do_txn("add", 5'b00001, 32'd5, 32'd7, 64'h0000_0000_0000_000C, 0, 0);
    endtask

    task automatic test_div();
        do_txn("div", 5'b00100, 32'd100, 32'd7, {32'd2, 32'd14}, 9, 0);
    endtask

    task automatic test_illegal();
        do_txn("illegal0", 5'b00000, 32'h1111_2222, 32'h3333_4444, 64'h5, 0, 0);
        do_txn("illegal16", 5'b10000, 32'hAAAA_5555, 32'h0F0F_F0F0, 64'h6, 0, 0);
    endtask

    task automatic test_timeout();
        do_txn("timeout", 5'd3, 32'h0000_0009, 32'h0000_0004, 64'h77, -1, 0);
        do_txn("done_at_63", 5'd3, 32'h0000_0019, 32'h0000_0005, 64'h1234_5678_9ABC_DEF0, 63, 0);
    endtask

    task automatic test_backpressure();
        do_txn("backpressure", 5'd2, 32'hCAFE_0001, 32'h0000_0002, 64'hFEED_FACE_0BAD_F00D, 2, 20);
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            int          r;
            int          d;
            logic [4:0]  op;
            logic [63:0] c;
            r  = int'($urandom_range(0, 9));
            d  = (r < 7) ? int'($urandom_range(0, 12)) : (r == 7 ? 63 : (r == 8 ? -1 : 62));
            op = 5'($urandom_range(0, 31));
            c  = {$urandom, $urandom};
            do_txn($sformatf("random%0d", n), op, $urandom, $urandom, c, d, int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_back_to_back();
        total++;
        if (both_hi != 0) begin
            bad++; $display("FAIL valid_and_ready_overlap: got %0d cycles want 0", both_hi);
        end
    endtask

    task automatic test_reset_mid();
        int quiet_bad;
        resp_delay = 5;
        resp_c     = 64'hABCD_EF01_2345_6789;
        req_valid = 1'b1; req_opcode = 5'd6; req_a = 32'hDEAD_BEEF; req_b = 32'h0BAD_CAFE;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        clr = 1'b1;
        #1;
        total++;
        if ({alu_y, alu_a, alu_b, alu_opcode, rsp_lo, rsp_hi, op_count} !== '0 ||
            alu_start !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
            bad++; $display("FAIL midreset_async: got y=%h a=%h op=%h cnt=%h v=%b rdy=%b want all 0",
                            alu_y, alu_a, alu_opcode, op_count, rsp_valid, req_ready);
        end
        @(posedge clk);
        #1;
        clr = 1'b0;
        exp_count = '0;
        #1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++; $display("FAIL midreset_ready: got %b want 1", req_ready);
        end
        quiet_bad = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || op_count !== 16'd0) quiet_bad++;
        end
        total++;
        if (quiet_bad != 0) begin
            bad++; $display("FAIL midreset_no_response: got %0d bad cycles want 0", quiet_bad);
        end
        do_txn("after_reset", 5'd7, 32'd3, 32'd4, 64'h42, 1, 0);
    endtask

    task automatic test_wrap();
        force dut.op_count = 16'hFFFF;
        #1;
        release dut.op_count;
        exp_count = 16'hFFFF;
        #1;
        total++;
        if (op_count !== 16'hFFFF) begin
            bad++; $display("FAIL wrap_preload: got %h want ffff", op_count);
        end
        do_txn("wrap", 5'd31, 32'd1, 32'd2, 64'h0, 0, 0);
        total++;
        if (op_count !== 16'h0000) begin
            bad++; $display("FAIL wrap_value: got %h want 0000", op_count);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_add();
        test_div();
        test_illegal();
        test_timeout();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_wrap();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
